// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and the atomic-sequencer state type for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int HZ_ST_W    = 2;

  typedef enum logic [HZ_ST_W-1:0] {
    HZ_ST_IDLE = 2'd0,
    HZ_ST_REQ  = 2'd1,
    HZ_ST_HOLD = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_cmp.sv
// Load-use comparator for one decode source port against the execute-stage load.
module hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic                  ex_reg_wr,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  id_valid,
  input  logic                  src_used,
  input  logic [REG_ADDR_W-1:0] src_addr,
  output logic                  hit
);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hit = ex_valid && ex_is_load && ex_reg_wr && (ex_rd != '0) &&
               id_valid && src_used && (src_addr == ex_rd);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Fetch/decode sequencing: load-use stalls, redirect kills, memory back-pressure,
// atomic lock handshake with the shared-memory arbiter, and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_r1_addr,
  input  logic [REG_ADDR_W-1:0] id_r2_addr,
  input  logic                  id_uses_r1,
  input  logic                  id_uses_r2,
  input  logic                  id_is_atomic,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic                  ex_reg_wr,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_redirect,
  input  logic                  mem_busy,
  input  logic                  mem_atomic_done,
  input  logic                  lock_gnt,
  output logic                  lock_req,
  output logic                  stall_fe,
  output logic                  stall_id,
  output logic                  stall_pipe,
  output logic                  id_kill,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [HZ_ST_W-1:0]    dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hz_state_e        state_q, state_d;
  logic             lock_req_q, lock_req_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic hit_r1, hit_r2, lu, atomic_in_id;
  logic fe_c, id_c, pipe_c, kill_c;

  hazard_cmp u_cmp_r1 (
    .ex_valid  (ex_valid),
    .ex_is_load(ex_is_load),
    .ex_reg_wr (ex_reg_wr),
    .ex_rd     (ex_rd),
    .id_valid  (id_valid),
    .src_used  (id_uses_r1),
    .src_addr  (id_r1_addr),
    .hit       (hit_r1)
  );

  hazard_cmp u_cmp_r2 (
    .ex_valid  (ex_valid),
    .ex_is_load(ex_is_load),
    .ex_reg_wr (ex_reg_wr),
    .ex_rd     (ex_rd),
    .id_valid  (id_valid),
    .src_used  (id_uses_r2),
    .src_addr  (id_r2_addr),
    .hit       (hit_r2)
  );

  assign lu           = hit_r1 || hit_r2;
  assign atomic_in_id = id_valid && id_is_atomic;

  always_comb begin
    state_d = state_q;
    fe_c    = 1'b0;
    id_c    = 1'b0;
    pipe_c  = 1'b0;
    kill_c  = 1'b0;
    if (mem_busy) begin
      // Whole pipe frozen; a pending grant is simply seen again next cycle.
      fe_c   = 1'b1;
      id_c   = 1'b1;
      pipe_c = 1'b1;
    end else if (ex_redirect) begin
      kill_c = 1'b1;
      if (state_q == HZ_ST_REQ) begin
        state_d = HZ_ST_IDLE;
      end else if (state_q == HZ_ST_HOLD && mem_atomic_done) begin
        state_d = HZ_ST_IDLE;
      end
    end else begin
      case (state_q)
        HZ_ST_IDLE: begin
          if (atomic_in_id && !lu) begin
            state_d = HZ_ST_REQ;
            fe_c    = 1'b1;
            kill_c  = 1'b1;
          end else if (lu) begin
            fe_c   = 1'b1;
            kill_c = 1'b1;
          end
        end
        HZ_ST_REQ: begin
          if (lock_gnt) begin
            state_d = HZ_ST_HOLD;
          end else begin
            fe_c   = 1'b1;
            kill_c = 1'b1;
          end
        end
        HZ_ST_HOLD: begin
          // A younger atomic waits here and is picked up from IDLE next cycle.
          if (mem_atomic_done) begin
            state_d = HZ_ST_IDLE;
          end
          if (atomic_in_id || lu) begin
            fe_c   = 1'b1;
            kill_c = 1'b1;
          end
        end
        default: state_d = HZ_ST_IDLE;
      endcase
    end
    if (rst) begin
      fe_c   = 1'b0;
      id_c   = 1'b0;
      pipe_c = 1'b0;
      kill_c = 1'b1;
    end
  end

  always_comb begin
    lock_req_d  = (state_d != HZ_ST_IDLE);
    stall_cnt_d = stall_cnt_q;
    if (fe_c && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HZ_ST_IDLE;
      lock_req_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lock_req_q  <= lock_req_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign lock_req   = lock_req_q;
  assign stall_fe   = fe_c;
  assign stall_id   = id_c;
  assign stall_pipe = pipe_c;
  assign id_kill    = kill_c;
  assign stall_cnt  = stall_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of the lock protocol and stall rules.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_SAT = 15;

  logic                  clk, rst;
  logic                  id_valid, id_uses_r1, id_uses_r2, id_is_atomic;
  logic [REG_ADDR_W-1:0] id_r1_addr, id_r2_addr, ex_rd;
  logic                  ex_valid, ex_is_load, ex_reg_wr, ex_redirect;
  logic                  mem_busy, mem_atomic_done, lock_gnt;
  logic                  lock_req, stall_fe, stall_id, stall_pipe, id_kill;
  logic [CNT_W-1:0]      stall_cnt;
  logic [HZ_ST_W-1:0]    dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  // Model: whether the core is waiting for the lock, whether it owns it, and the stall count.
  bit m_waiting, m_owns;
  int m_cnt;
  bit e_fe, e_id, e_pipe, e_kill, n_waiting, n_owns;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_r1_addr(id_r1_addr), .id_r2_addr(id_r2_addr),
    .id_uses_r1(id_uses_r1), .id_uses_r2(id_uses_r2), .id_is_atomic(id_is_atomic),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_reg_wr(ex_reg_wr), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .mem_atomic_done(mem_atomic_done),
    .lock_gnt(lock_gnt), .lock_req(lock_req), .stall_fe(stall_fe), .stall_id(stall_id),
    .stall_pipe(stall_pipe), .id_kill(id_kill), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_eval();
    bit dep, atom;
    dep = ex_valid && ex_is_load && ex_reg_wr && (ex_rd != 0) && id_valid &&
          ((id_uses_r1 && id_r1_addr == ex_rd) || (id_uses_r2 && id_r2_addr == ex_rd));
    atom = id_valid && id_is_atomic;
    e_fe = 0; e_id = 0; e_pipe = 0; e_kill = 0;
    n_waiting = m_waiting; n_owns = m_owns;
    if (mem_busy) begin
      e_fe = 1; e_id = 1; e_pipe = 1;
    end else if (ex_redirect) begin
      e_kill = 1;
      n_waiting = 0;
      if (m_owns && mem_atomic_done) n_owns = 0;
    end else if (m_waiting) begin
      if (lock_gnt) begin n_waiting = 0; n_owns = 1; end
      else begin e_fe = 1; e_kill = 1; end
    end else if (m_owns) begin
      if (mem_atomic_done) n_owns = 0;
      if (atom || dep) begin e_fe = 1; e_kill = 1; end
    end else begin
      if (atom && !dep) n_waiting = 1;
      if (atom || dep) begin e_fe = 1; e_kill = 1; end
    end
  endfunction

  function automatic int exp_state();
    return m_owns ? 2 : (m_waiting ? 1 : 0);
  endfunction

  task automatic cycle();
    model_eval();
    @(posedge clk);
    m_waiting = n_waiting;
    m_owns    = n_owns;
    if (e_fe && m_cnt < CNT_SAT) m_cnt++;
    #1;
  endtask

  task automatic drive_idle();
    id_valid = 0; id_r1_addr = 0; id_r2_addr = 0; id_uses_r1 = 0; id_uses_r2 = 0;
    id_is_atomic = 0; ex_valid = 0; ex_is_load = 0; ex_reg_wr = 0; ex_rd = 0;
    ex_redirect = 0; mem_busy = 0; mem_atomic_done = 0; lock_gnt = 0;
  endtask

  task automatic drive_load_use(input logic [REG_ADDR_W-1:0] rd);
    ex_valid = 1; ex_is_load = 1; ex_reg_wr = 1; ex_rd = rd;
    id_valid = 1; id_uses_r1 = 1; id_r1_addr = rd;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    m_waiting = 0; m_owns = 0; m_cnt = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1;
    #2;
    n_total++; if (id_kill !== 1'b1) begin n_bad++; $display("FAIL rst_kill: got %0b want 1", id_kill); end
    n_total++; if (lock_req !== 1'b0) begin n_bad++; $display("FAIL rst_lock_req: got %0b want 0", lock_req); end
    n_total++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
    n_total++; if (stall_fe !== 1'b0) begin n_bad++; $display("FAIL rst_fe: got %0b want 0", stall_fe); end
    do_reset();
    #2;
    n_total++; if (id_kill !== 1'b0) begin n_bad++; $display("FAIL post_rst_kill: got %0b want 0", id_kill); end
    n_total++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL post_rst_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_load_use();
    drive_idle();
    drive_load_use(5);
    #2;
    n_total++; if (stall_fe !== 1'b1) begin n_bad++; $display("FAIL lu_fe: got %0b want 1", stall_fe); end
    n_total++; if (id_kill !== 1'b1) begin n_bad++; $display("FAIL lu_kill: got %0b want 1", id_kill); end
    n_total++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL lu_id: got %0b want 0", stall_id); end
    cycle();
    ex_valid = 0; ex_is_load = 0;
    #2;
    n_total++; if (stall_fe !== 1'b0) begin n_bad++; $display("FAIL lu_one_cycle: got %0b want 0", stall_fe); end
    n_total++; if (stall_cnt !== 4'd1) begin n_bad++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
    cycle();
    drive_load_use(0);
    #2;
    n_total++; if (stall_fe !== 1'b0) begin n_bad++; $display("FAIL lu_r0: got %0b want 0", stall_fe); end
    ex_rd = 7; id_r1_addr = 6; id_uses_r2 = 1; id_r2_addr = 7;
    #1;
    n_total++; if (stall_fe !== 1'b1) begin n_bad++; $display("FAIL lu_r2: got %0b want 1", stall_fe); end
    cycle();
    drive_idle();
    cycle();
  endtask

  task automatic test_redirect();
    drive_idle();
    drive_load_use(9);
    ex_redirect = 1;
    #2;
    n_total++; if (id_kill !== 1'b1) begin n_bad++; $display("FAIL redir_kill: got %0b want 1", id_kill); end
    n_total++; if (stall_fe !== 1'b0) begin n_bad++; $display("FAIL redir_fe: got %0b want 0", stall_fe); end
    cycle();
    drive_idle();
    cycle();
  endtask

  task automatic test_atomic();
    int base;
    drive_idle();
    base = m_cnt;
    id_valid = 1; id_is_atomic = 1;
    #2;
    n_total++; if (stall_fe !== 1'b1 || id_kill !== 1'b1) begin n_bad++; $display("FAIL atom_detect: got fe=%0b kill=%0b want 1/1", stall_fe, id_kill); end
    n_total++; if (lock_req !== 1'b0) begin n_bad++; $display("FAIL atom_req_early: got %0b want 0", lock_req); end
    cycle();
    for (int i = 0; i < 3; i++) begin
      #2;
      n_total++; if (lock_req !== 1'b1 || stall_fe !== 1'b1) begin n_bad++; $display("FAIL atom_wait%0d: got req=%0b fe=%0b want 1/1", i, lock_req, stall_fe); end
      cycle();
    end
    lock_gnt = 1;
    #2;
    n_total++; if (stall_fe !== 1'b0 || id_kill !== 1'b0) begin n_bad++; $display("FAIL atom_issue: got fe=%0b kill=%0b want 0/0", stall_fe, id_kill); end
    cycle();
    id_is_atomic = 0;
    #2;
    n_total++; if (stall_cnt !== 4'(base + 4)) begin n_bad++; $display("FAIL atom_cnt: got %0d want %0d", stall_cnt, base + 4); end
    n_total++; if (dbg_state !== 2'd2 || lock_req !== 1'b1) begin n_bad++; $display("FAIL atom_hold: got st=%0d req=%0b want 2/1", dbg_state, lock_req); end
    cycle();
    mem_atomic_done = 1;
    #2;
    n_total++; if (lock_req !== 1'b1) begin n_bad++; $display("FAIL atom_done_req: got %0b want 1", lock_req); end
    cycle();
    drive_idle();
    #2;
    n_total++; if (lock_req !== 1'b0 || dbg_state !== 2'd0) begin n_bad++; $display("FAIL atom_release: got req=%0b st=%0d want 0/0", lock_req, dbg_state); end
    cycle();
  endtask

  task automatic test_back_pressure();
    drive_idle();
    id_valid = 1; id_is_atomic = 1;
    cycle();
    lock_gnt = 1; mem_busy = 1;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_total++; if ({stall_fe, stall_id, stall_pipe, id_kill} !== 4'b1110) begin n_bad++; $display("FAIL bp_stalls%0d: got %b want 1110", i, {stall_fe, stall_id, stall_pipe, id_kill}); end
      cycle();
      n_total++; if (dbg_state !== 2'd1) begin n_bad++; $display("FAIL bp_state%0d: got %0d want 1", i, dbg_state); end
    end
    mem_busy = 0;
    #2;
    n_total++; if (stall_fe !== 1'b0 || id_kill !== 1'b0) begin n_bad++; $display("FAIL bp_issue: got fe=%0b kill=%0b want 0/0", stall_fe, id_kill); end
    cycle();
    id_is_atomic = 0; mem_atomic_done = 1;
    cycle();
    drive_idle();
    cycle();
  endtask

  task automatic test_redirect_req();
    drive_idle();
    id_valid = 1; id_is_atomic = 1;
    cycle();
    ex_redirect = 1;
    #2;
    n_total++; if (id_kill !== 1'b1 || stall_fe !== 1'b0) begin n_bad++; $display("FAIL rreq_out: got kill=%0b fe=%0b want 1/0", id_kill, stall_fe); end
    cycle();
    drive_idle();
    #2;
    n_total++; if (lock_req !== 1'b0 || dbg_state !== 2'd0) begin n_bad++; $display("FAIL rreq_idle: got req=%0b st=%0d want 0/0", lock_req, dbg_state); end
    cycle();
  endtask

  task automatic test_reset_mid_hold();
    drive_idle();
    id_valid = 1; id_is_atomic = 1;
    cycle();
    lock_gnt = 1;
    cycle();
    lock_gnt = 0;
    #2;
    n_total++; if (dbg_state !== 2'd2) begin n_bad++; $display("FAIL mh_hold: got %0d want 2", dbg_state); end
    rst = 1;
    #1;
    n_total++; if (lock_req !== 1'b0) begin n_bad++; $display("FAIL mh_req_async: got %0b want 0", lock_req); end
    n_total++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL mh_cnt: got %0d want 0", stall_cnt); end
    n_total++; if (id_kill !== 1'b1 || stall_fe !== 1'b0) begin n_bad++; $display("FAIL mh_outs: got kill=%0b fe=%0b want 1/0", id_kill, stall_fe); end
    drive_idle();
    do_reset();
  endtask

  task automatic test_saturate();
    drive_idle();
    drive_load_use(3);
    for (int i = 0; i < 20; i++) begin
      if (i == 15) begin
        #2;
        n_total++; if (stall_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_at15: got %0d want 15", stall_cnt); end
      end
      cycle();
    end
    #2;
    n_total++; if (stall_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_cnt: got %0d want 15", stall_cnt); end
    drive_idle();
    cycle();
  endtask

  task automatic test_random();
    drive_idle();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      id_valid        = ($urandom_range(0, 9) < 8);
      id_r1_addr      = REG_ADDR_W'($urandom_range(0, 3));
      id_r2_addr      = REG_ADDR_W'($urandom_range(0, 3));
      id_uses_r1      = $urandom_range(0, 1) != 0;
      id_uses_r2      = $urandom_range(0, 1) != 0;
      id_is_atomic    = ($urandom_range(0, 9) < 2);
      ex_valid        = ($urandom_range(0, 9) < 8);
      ex_is_load      = $urandom_range(0, 1) != 0;
      ex_reg_wr       = ($urandom_range(0, 9) < 8);
      ex_rd           = REG_ADDR_W'($urandom_range(0, 3));
      ex_redirect     = ($urandom_range(0, 9) < 1);
      mem_busy        = ($urandom_range(0, 19) < 3);
      mem_atomic_done = ($urandom_range(0, 9) < 3);
      lock_gnt        = ($urandom_range(0, 9) < 4);
      #2;
      model_eval();
      n_total++; if (stall_fe !== e_fe) begin n_bad++; $display("FAIL rnd_fe@%0d: got %0b want %0b", i, stall_fe, e_fe); end
      n_total++; if (stall_id !== e_id) begin n_bad++; $display("FAIL rnd_id@%0d: got %0b want %0b", i, stall_id, e_id); end
      n_total++; if (stall_pipe !== e_pipe) begin n_bad++; $display("FAIL rnd_pipe@%0d: got %0b want %0b", i, stall_pipe, e_pipe); end
      n_total++; if (id_kill !== e_kill) begin n_bad++; $display("FAIL rnd_kill@%0d: got %0b want %0b", i, id_kill, e_kill); end
      n_total++; if (lock_req !== (m_waiting || m_owns)) begin n_bad++; $display("FAIL rnd_req@%0d: got %0b want %0b", i, lock_req, m_waiting || m_owns); end
      n_total++; if (int'(stall_cnt) != m_cnt) begin n_bad++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", i, stall_cnt, m_cnt); end
      n_total++; if (int'(dbg_state) != exp_state()) begin n_bad++; $display("FAIL rnd_state@%0d: got %0d want %0d", i, dbg_state, exp_state()); end
      cycle();
    end
    drive_idle();
  endtask

  initial begin
    m_waiting = 0; m_owns = 0; m_cnt = 0;
    test_reset();
    test_load_use();
    test_redirect();
    test_atomic();
    test_back_pressure();
    test_redirect_req();
    test_reset_mid_hold();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Per-core pipeline controller that sequences the fetch and decode stages and the decode-to-execute register. It detects load-use hazards and branch/jump redirects, honours memory-stage back-pressure, and serialises atomic instructions through a lock handshake with the shared-memory arbiter. It drives the decode stage's `stall` input and the flush input that accompanies each fetched instruction. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clk`  in  1: core clock.
- `rst`  in  1: asynchronous, active-high reset.
- `id_valid`  in  1: decode holds a live instruction, i.e. its flush input is low.
- `id_r1_addr`, `id_r2_addr`  in  `REG_ADDR_W`: source registers of the decode instruction.
- `id_uses_r1`, `id_uses_r2`  in  1: the decode instruction actually reads r1 / r2.
- `id_is_atomic`  in  1: the decode instruction is an atomic memory operation.
- `ex_valid`  in  1: execute holds a live instruction (decode stage's `out_flush` low).
- `ex_is_load`, `ex_reg_wr`  in  1: the execute instruction is a load / writes a register.
- `ex_rd`  in  `REG_ADDR_W`: destination register of the execute instruction.
- `ex_redirect`  in  1: a taken branch or jump has resolved in execute.
- `mem_busy`  in  1: the memory stage cannot advance this cycle.
- `mem_atomic_done`  in  1: the atomic's memory access completed this cycle.
- `lock_gnt`  in  1: the shared-memory arbiter grants the lock.
- `lock_req`  out  1: lock request to the arbiter (registered).
- `stall_fe`  out  1: hold the fetch stage's PC and instruction.
- `stall_id`  out  1: hold the decode pipeline registers.
- `stall_pipe`  out  1: hold execute and later stages.
- `id_kill`  out  1: ORed into the decode stage's flush input, so decode registers a bubble.
- `stall_cnt`  out  `CNT_W`: saturating count of cycles with `stall_fe`=1.

## Operation
- **Load-use hazard (`lu`):** `ex_valid & ex_is_load & ex_reg_wr & ex_rd!=0 & id_valid & ((id_uses_r1 & id_r1_addr==ex_rd) | (id_uses_r2 & id_r2_addr==ex_rd))`.
- **Priority, highest first:**
  - `mem_busy`: `stall_fe=stall_id=stall_pipe=1`, `id_kill=0`, FSM frozen.
  - `ex_redirect`: `id_kill=1`, all stalls 0. Fetch applies the redirect itself.
  - Atomic FSM actions (below).
  - `lu`: `stall_fe=1`, `id_kill=1`, `stall_id=0`. One bubble enters execute and the decode instruction is re-presented.
  - Otherwise all outputs are 0.
- **Atomic FSM states:** IDLE, REQ, HOLD.
  - IDLE: if `id_valid & id_is_atomic & !lu`, go to REQ next cycle. That cycle is treated as a stall: `stall_fe=1`, `id_kill=1`.
  - REQ: `lock_req=1`, `stall_fe=1`, `id_kill=1` while `!lock_gnt`.
    - On `lock_gnt`, the atomic issues that cycle (no kill, no stall) and the FSM goes to HOLD.
    - `ex_redirect` in REQ returns to IDLE and drops `lock_req`.
  - HOLD: `lock_req=1`. Any further atomic in decode is stalled as in REQ.
    - On `mem_atomic_done`, go to IDLE.
    - `ex_redirect` in HOLD does not change state, because the atomic is older than anything in execute.
- **`lock_req`:** registered, equal to (next state ≠ IDLE). It rises one cycle after the atomic is seen in decode and falls the cycle after `mem_atomic_done`.
- **`stall_cnt`:** increments when `stall_fe=1` and saturates at all-ones.

## Timing
- All stall and kill outputs are combinational from the inputs plus FSM state, with zero-cycle latency. `lock_req` and `stall_cnt` are registered.
- **Reset:** while `rst` is high, state=IDLE, `lock_req`=0, `stall_cnt`=0, `stall_*`=0, `id_kill`=1.
  - Reset mid-HOLD releases the lock immediately (asynchronously).
- **Load-use:** exactly one stall cycle per hazard. The next cycle the load has moved to memory, so `lu`=0.
- **Simultaneous events:**
  - `mem_busy` together with `lock_gnt` in REQ: the grant is ignored that cycle. The arbiter holds `lock_gnt` until `lock_req` drops.
  - `mem_atomic_done` together with a new atomic in decode: go to IDLE, and that atomic is detected the following cycle.

## Structure
- Add to `defines.vh`: `HZ_ST_W`=2, `HZ_ST_IDLE`=0, `HZ_ST_REQ`=1, `HZ_ST_HOLD`=2. `REG_ADDR_W` already exists there.
- One sub-module, `hazard_cmp`: a purely combinational load-use comparator for one source port, instantiated twice.
- The FSM and the counter stay in the top module.

## Test plan
- **Load-use:** `ex_is_load=1`, `ex_rd=5`, `id_r1_addr=5`, `id_uses_r1=1` → one cycle of `stall_fe=1`, `id_kill=1`, `stall_id=0`; `stall_cnt` 0→1. With `ex_rd=0` → no stall.
- **Redirect over hazard:** `ex_redirect=1` with the same load-use → `id_kill=1`, `stall_fe=0`.
- **Atomic:** atomic in decode, `lock_gnt` arrives 3 cycles after `lock_req` rises → 4 stalled cycles, issue on the grant cycle, `lock_req` held until `mem_atomic_done`, low the cycle after.
- **Back-pressure:** `mem_busy=1` for 2 cycles in REQ with `lock_gnt=1` → all stalls high, FSM stays REQ, issue on the first cycle `mem_busy=0`.
- **Redirect during REQ:** `ex_redirect` in REQ → IDLE, `lock_req` 0 next cycle.
- **Reset mid-HOLD:** assert `rst` → `lock_req` 0 asynchronously, `stall_cnt` 0, `id_kill` 1. With `CNT_W`=4, 20 stall cycles → `stall_cnt`=15.
